time_entry_assembler: RTL and testbench
=======================================

TIME_ENTRY_ASSEMBLER -- requirements
Module: time_entry_assembler

Interface
REQ-001 SHALL use `clk`, input, 1 bit, the single rising-edge clock for all state.
REQ-002 SHALL use `reset`, input, 1 bit, synchronous active-high reset, sampled on the `clk` rising edge.
REQ-003 SHALL have `key_valid`, input, 1 bit, a one-cycle strobe marking that `key_digit` is valid.
REQ-004 SHALL have `key_digit`, input, 4 bits, the keypad digit value (0-15).
REQ-005 SHALL have `commit`, input, 1 bit, a one-cycle strobe requesting conversion of the entered digits.
REQ-006 SHALL have `clear`, input, 1 bit, a one-cycle strobe that discards the entry.
REQ-007 SHALL have `ent_D3`, `ent_D2`, `ent_D1`, `ent_D0`, outputs, 4 bits each, the echo of the entered digits as M-tens, M-ones, S-tens, S-ones.
REQ-008 SHALL have `digit_count`, output, 3 bits, the number of digits entered (0-4).
REQ-009 SHALL have `minutes` and `seconds`, outputs, 6 bits each, the converted binary time, range 0-59.
REQ-010 SHALL have `time_valid`, output, 1 bit, a one-cycle pulse when `minutes` and `seconds` are updated.
REQ-011 SHALL have `range_err`, output, 1 bit, held high while the last committed value was saturated.

Function
REQ-012 SHALL implement four states: EMPTY, ENTRY, CONV and HOLD.
REQ-013 SHALL treat a key with `key_digit` greater than 9 as a no-op in every state.
REQ-014 SHALL, on a valid digit in EMPTY or ENTRY, shift the digits left (D3<-D2, D2<-D1, D1<-D0, D0<-key), saturate `digit_count` at 4 (discarding the oldest digit), and enter or stay in ENTRY.
REQ-015 SHALL, on a valid digit in HOLD, zero all digits, load the key into D0, set `digit_count` to 1, deassert `range_err`, and go to ENTRY.
REQ-016 SHALL, on `commit` in ENTRY, go to CONV; `commit` in EMPTY, CONV or HOLD SHALL be ignored.
REQ-017 SHALL, in CONV (exactly one cycle), compute m = D3*10+D2 and s = D1*10+D0.
REQ-018 SHALL normalize s of 60 or more to s-60 and m+1 (microwave style, e.g. "90" gives 1:30).
REQ-019 SHALL, if the normalized m exceeds 59, set `minutes` = 59 and `seconds` = 59 and assert `range_err`; otherwise it SHALL deassert `range_err`.
REQ-020 SHALL register the results, pulse `time_valid` in the first HOLD cycle, and give a fixed latency of `commit` sampled at edge N to `time_valid` high after edge N+2.
REQ-021 SHALL hold `minutes`, `seconds` and `range_err` stable until the next conversion, `clear` or `reset`.
REQ-022 SHALL ignore keys and `commit` while in CONV.
REQ-023 SHALL, on `clear` in any state, zero the digits and `digit_count` and go to EMPTY, keeping `minutes` and `seconds` and deasserting `range_err`.
REQ-024 SHALL resolve simultaneous strobes by priority: `reset` > `clear` > `commit` > `key_valid`; the losers are dropped, not queued.
REQ-025 SHALL perform the intermediate arithmetic at least 7 bits wide (99+1=100) and truncate to 6 bits only after saturation.

Reset
REQ-026 SHALL, on `reset`, set state to EMPTY, zero all digit outputs, `digit_count`, `minutes` and `seconds`, and hold `time_valid` and `range_err` at 0.
REQ-027 SHALL, on `reset` asserted in CONV, abort the conversion with no `time_valid` pulse.

Structure
REQ-028 SHALL place the state encoding, MAX_MIN=59, MAX_SEC=59 and DIGIT_W=4 in the shared package `microwave_pkg`.
REQ-029 SHALL use the combinational sub-module `bcd_pair_to_bin` (inputs tens and ones, 4 bits each; output 7-bit binary), instantiated twice for the minutes and seconds pairs.
REQ-030 SHALL have no latches, with all outputs driven from registers.

Verification
REQ-031 SHALL cover: keys 1,3,0 then `commit` -> 1:30, with `time_valid` high after edge N+2 and `digit_count`=3.
REQ-032 SHALL cover: keys 9,0 then `commit` -> 1:30, with `range_err`=0.
REQ-033 SHALL cover: keys 9,9,9,9 then `commit` -> 59:59, with `range_err`=1; a following key 5 -> ENTRY, D0=5, `range_err`=0.
REQ-034 SHALL cover: keys 1,2,3,4,5 -> D3..D0=2,3,4,5 and `digit_count`=4; `commit` -> 23:45.
REQ-035 SHALL cover: key 12 (invalid) in EMPTY -> no change, and `commit` in EMPTY -> no `time_valid`.
REQ-036 SHALL cover: `clear` and `commit` asserted together in ENTRY -> EMPTY with no `time_valid`; `reset` in CONV -> all outputs 0 and no pulse.

Source files
------------

// File: rtl/microwave_pkg.sv
// Shared widths, limits and FSM encoding for the microwave time-entry block.
package microwave_pkg;

  localparam int unsigned DIGIT_W   = 4;
  localparam int unsigned CNT_W     = 3;
  localparam int unsigned BIN_W     = 7;
  localparam int unsigned OUT_W     = 6;
  localparam int unsigned MAX_MIN   = 59;
  localparam int unsigned MAX_SEC   = 59;
  localparam int unsigned MAX_DIGIT = 9;
  localparam int unsigned MAX_CNT   = 4;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ENTRY = 2'd1,
    ST_CONV  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/bcd_pair_to_bin.sv
// Combinational tens/ones BCD pair to 7-bit binary (0-99 for legal digits).
module bcd_pair_to_bin
  import microwave_pkg::*;
(
  input  logic [DIGIT_W-1:0] tens,
  input  logic [DIGIT_W-1:0] ones,
  output logic [BIN_W-1:0]   bin
);

  assign bin = (BIN_W'(tens) * BIN_W'(10)) + BIN_W'(ones);

endmodule

// File: rtl/time_entry_assembler.sv
// Keypad digit collector that converts an MM:SS entry to binary minutes/seconds.
module time_entry_assembler
  import microwave_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               key_valid,
  input  logic [DIGIT_W-1:0] key_digit,
  input  logic               commit,
  input  logic               clear,
  output logic [DIGIT_W-1:0] ent_D3,
  output logic [DIGIT_W-1:0] ent_D2,
  output logic [DIGIT_W-1:0] ent_D1,
  output logic [DIGIT_W-1:0] ent_D0,
  output logic [CNT_W-1:0]   digit_count,
  output logic [OUT_W-1:0]   minutes,
  output logic [OUT_W-1:0]   seconds,
  output logic               time_valid,
  output logic               range_err
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [DIGIT_W-1:0] r_d3, r_d2, r_d1, r_d0;
  logic [DIGIT_W-1:0] w_d3, w_d2, w_d1, w_d0;
  logic [CNT_W-1:0]   r_cnt, w_cnt, w_cnt_inc;
  logic [OUT_W-1:0]   r_min, r_sec, w_min, w_sec;
  logic               r_tv, w_tv, r_re, w_re;
  // Conversion results are staged in CONV and published on the first HOLD edge.
  logic [OUT_W-1:0]   r_stage_m, r_stage_s, w_stage_m, w_stage_s;
  logic               r_stage_sat, w_stage_sat;
  logic               r_pub, w_pub;

  logic [BIN_W-1:0]   w_m_raw, w_s_raw, w_m_norm, w_s_norm;
  logic               w_sat;
  logic [OUT_W-1:0]   w_m_fin, w_s_fin;
  logic               w_key_ok;

  bcd_pair_to_bin u_min_pair (.tens(r_d3), .ones(r_d2), .bin(w_m_raw));
  bcd_pair_to_bin u_sec_pair (.tens(r_d1), .ones(r_d0), .bin(w_s_raw));

  assign w_key_ok  = key_valid && (key_digit <= DIGIT_W'(MAX_DIGIT));
  assign w_cnt_inc = (r_cnt == CNT_W'(MAX_CNT)) ? r_cnt : r_cnt + CNT_W'(1);

  // Microwave-style carry of seconds >= 60 into minutes, then saturate at 59:59.
  always_comb begin
    w_m_norm = w_m_raw;
    w_s_norm = w_s_raw;
    if (w_s_raw >= BIN_W'(MAX_SEC + 1)) begin
      w_s_norm = w_s_raw - BIN_W'(MAX_SEC + 1);
      w_m_norm = w_m_raw + BIN_W'(1);
    end
    w_sat   = (w_m_norm > BIN_W'(MAX_MIN));
    w_m_fin = w_sat ? OUT_W'(MAX_MIN) : w_m_norm[OUT_W-1:0];
    w_s_fin = w_sat ? OUT_W'(MAX_SEC) : w_s_norm[OUT_W-1:0];
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_EMPTY;
    else       r_state <= w_state_nxt;
  end

  // Next-state and next-datapath logic; clear beats commit beats key.
  always_comb begin
    w_state_nxt = r_state;
    w_d3        = r_d3;
    w_d2        = r_d2;
    w_d1        = r_d1;
    w_d0        = r_d0;
    w_cnt       = r_cnt;
    w_min       = r_min;
    w_sec       = r_sec;
    w_tv        = 1'b0;
    w_re        = r_re;
    w_pub       = 1'b0;
    w_stage_m   = r_stage_m;
    w_stage_s   = r_stage_s;
    w_stage_sat = r_stage_sat;

    if (clear) begin
      w_state_nxt = ST_EMPTY;
      w_d3        = '0;
      w_d2        = '0;
      w_d1        = '0;
      w_d0        = '0;
      w_cnt       = '0;
      w_re        = 1'b0;
    end else begin
      if ((r_state == ST_HOLD) && r_pub) begin
        w_min = r_stage_m;
        w_sec = r_stage_s;
        w_re  = r_stage_sat;
        w_tv  = 1'b1;
      end
      case (r_state)
        ST_EMPTY, ST_ENTRY: begin
          if ((r_state == ST_ENTRY) && commit) begin
            w_state_nxt = ST_CONV;
          end else if (w_key_ok) begin
            w_d3        = r_d2;
            w_d2        = r_d1;
            w_d1        = r_d0;
            w_d0        = key_digit;
            w_cnt       = w_cnt_inc;
            w_state_nxt = ST_ENTRY;
          end
        end
        ST_CONV: begin
          w_stage_m   = w_m_fin;
          w_stage_s   = w_s_fin;
          w_stage_sat = w_sat;
          w_pub       = 1'b1;
          w_state_nxt = ST_HOLD;
        end
        ST_HOLD: begin
          if (w_key_ok) begin
            w_d3        = '0;
            w_d2        = '0;
            w_d1        = '0;
            w_d0        = key_digit;
            w_cnt       = CNT_W'(1);
            w_re        = 1'b0;
            w_state_nxt = ST_ENTRY;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_d3        <= '0;
      r_d2        <= '0;
      r_d1        <= '0;
      r_d0        <= '0;
      r_cnt       <= '0;
      r_min       <= '0;
      r_sec       <= '0;
      r_tv        <= 1'b0;
      r_re        <= 1'b0;
      r_pub       <= 1'b0;
      r_stage_m   <= '0;
      r_stage_s   <= '0;
      r_stage_sat <= 1'b0;
    end else begin
      r_d3        <= w_d3;
      r_d2        <= w_d2;
      r_d1        <= w_d1;
      r_d0        <= w_d0;
      r_cnt       <= w_cnt;
      r_min       <= w_min;
      r_sec       <= w_sec;
      r_tv        <= w_tv;
      r_re        <= w_re;
      r_pub       <= w_pub;
      r_stage_m   <= w_stage_m;
      r_stage_s   <= w_stage_s;
      r_stage_sat <= w_stage_sat;
    end
  end

  assign ent_D3      = r_d3;
  assign ent_D2      = r_d2;
  assign ent_D1      = r_d1;
  assign ent_D0      = r_d0;
  assign digit_count = r_cnt;
  assign minutes     = r_min;
  assign seconds     = r_sec;
  assign time_valid  = r_tv;
  assign range_err   = r_re;

endmodule

// File: tb/tb_time_entry_assembler.sv
// Directed table-driven bench for time_entry_assembler.
module tb_time_entry_assembler;

  logic       clk;
  logic       reset;
  logic       key_valid;
  logic [3:0] key_digit;
  logic       commit;
  logic       clear;
  logic [3:0] ent_D3, ent_D2, ent_D1, ent_D0;
  logic [2:0] digit_count;
  logic [5:0] minutes, seconds;
  logic       time_valid;
  logic       range_err;

  int errors = 0;
  int checks = 0;
  int lat;

  time_entry_assembler dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_digit(key_digit),
    .commit(commit), .clear(clear),
    .ent_D3(ent_D3), .ent_D2(ent_D2), .ent_D1(ent_D1), .ent_D0(ent_D0),
    .digit_count(digit_count), .minutes(minutes), .seconds(seconds),
    .time_valid(time_valid), .range_err(range_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        kv;
    logic [3:0]  kd;
    logic        cm;
    logic        cl;
    logic [15:0] dig;
    logic [2:0]  cnt;
    logic        tv;
    logic [5:0]  mn;
    logic [5:0]  sc;
    logic        re;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic kv, input logic [3:0] kd,
                              input logic cm, input logic cl, input logic [15:0] dig,
                              input logic [2:0] cnt, input logic tv, input logic [5:0] mn,
                              input logic [5:0] sc, input logic re);
    vec_t v;
    v.rst = rst; v.kv = kv; v.kd = kd; v.cm = cm; v.cl = cl;
    v.dig = dig; v.cnt = cnt; v.tv = tv; v.mn = mn; v.sc = sc; v.re = re;
    return v;
  endfunction

  task automatic chk(input string name, input int row, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h want %0h", name, row, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] d);
    key_valid = 1'b1;
    key_digit = d;
    step();
    key_valid = 1'b0;
    key_digit = 4'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; key_valid = 1'b0; key_digit = 4'd0; commit = 1'b0; clear = 1'b0;

    //                 rst kv kd     cm cl dig       cnt tv mn  sc  re
    // reset state, invalid key and commit in EMPTY
    vecs.push_back(mk(1, 0, 4'd0,  0, 0, 16'h0000, 0, 0, 0,  0,  0));
    vecs.push_back(mk(1, 0, 4'd0,  0, 0, 16'h0000, 0, 0, 0,  0,  0));
    vecs.push_back(mk(0, 1, 4'd12, 0, 0, 16'h0000, 0, 0, 0,  0,  0));
    vecs.push_back(mk(0, 0, 4'd0,  1, 0, 16'h0000, 0, 0, 0,  0,  0));
    vecs.push_back(mk(0, 0, 4'd0,  0, 0, 16'h0000, 0, 0, 0,  0,  0));
    vecs.push_back(mk(0, 0, 4'd0,  0, 0, 16'h0000, 0, 0, 0,  0,  0));
    // 1,3,0 commit -> 1:30, pulse two edges after commit
    vecs.push_back(mk(0, 1, 4'd1,  0, 0, 16'h0001, 1, 0, 0,  0,  0));
    vecs.push_back(mk(0, 1, 4'd3,  0, 0, 16'h0013, 2, 0, 0,  0,  0));
    vecs.push_back(mk(0, 1, 4'd0,  0, 0, 16'h0130, 3, 0, 0,  0,  0));
    vecs.push_back(mk(0, 0, 4'd0,  1, 0, 16'h0130, 3, 0, 0,  0,  0));
    vecs.push_back(mk(0, 0, 4'd0,  0, 0, 16'h0130, 3, 0, 0,  0,  0));
    vecs.push_back(mk(0, 0, 4'd0,  0, 0, 16'h0130, 3, 1, 1,  30, 0));
    vecs.push_back(mk(0, 0, 4'd0,  0, 0, 16'h0130, 3, 0, 1,  30, 0));
    // 9,0 from HOLD -> 1:30
    vecs.push_back(mk(0, 1, 4'd9,  0, 0, 16'h0009, 1, 0, 1,  30, 0));
    vecs.push_back(mk(0, 1, 4'd0,  0, 0, 16'h0090, 2, 0, 1,  30, 0));
    vecs.push_back(mk(0, 0, 4'd0,  1, 0, 16'h0090, 2, 0, 1,  30, 0));
    vecs.push_back(mk(0, 0, 4'd0,  0, 0, 16'h0090, 2, 0, 1,  30, 0));
    vecs.push_back(mk(0, 0, 4'd0,  0, 0, 16'h0090, 2, 1, 1,  30, 0));
    vecs.push_back(mk(0, 0, 4'd0,  0, 0, 16'h0090, 2, 0, 1,  30, 0));
    // 9,9,9,9 -> saturate 59:59, then key 5 drops range_err
    vecs.push_back(mk(0, 1, 4'd9,  0, 0, 16'h0009, 1, 0, 1,  30, 0));
    vecs.push_back(mk(0, 1, 4'd9,  0, 0, 16'h0099, 2, 0, 1,  30, 0));
    vecs.push_back(mk(0, 1, 4'd9,  0, 0, 16'h0999, 3, 0, 1,  30, 0));
    vecs.push_back(mk(0, 1, 4'd9,  0, 0, 16'h9999, 4, 0, 1,  30, 0));
    vecs.push_back(mk(0, 0, 4'd0,  1, 0, 16'h9999, 4, 0, 1,  30, 0));
    vecs.push_back(mk(0, 0, 4'd0,  0, 0, 16'h9999, 4, 0, 1,  30, 0));
    vecs.push_back(mk(0, 0, 4'd0,  0, 0, 16'h9999, 4, 1, 59, 59, 1));
    vecs.push_back(mk(0, 0, 4'd0,  0, 0, 16'h9999, 4, 0, 59, 59, 1));
    vecs.push_back(mk(0, 1, 4'd5,  0, 0, 16'h0005, 1, 0, 59, 59, 0));
    // clear, then 1..5 saturates count at 4 -> 23:45
    vecs.push_back(mk(0, 0, 4'd0,  0, 1, 16'h0000, 0, 0, 59, 59, 0));
    vecs.push_back(mk(0, 1, 4'd1,  0, 0, 16'h0001, 1, 0, 59, 59, 0));
    vecs.push_back(mk(0, 1, 4'd2,  0, 0, 16'h0012, 2, 0, 59, 59, 0));
    vecs.push_back(mk(0, 1, 4'd3,  0, 0, 16'h0123, 3, 0, 59, 59, 0));
    vecs.push_back(mk(0, 1, 4'd4,  0, 0, 16'h1234, 4, 0, 59, 59, 0));
    vecs.push_back(mk(0, 1, 4'd5,  0, 0, 16'h2345, 4, 0, 59, 59, 0));
    vecs.push_back(mk(0, 0, 4'd0,  1, 0, 16'h2345, 4, 0, 59, 59, 0));
    vecs.push_back(mk(0, 0, 4'd0,  0, 0, 16'h2345, 4, 0, 59, 59, 0));
    vecs.push_back(mk(0, 0, 4'd0,  0, 0, 16'h2345, 4, 1, 23, 45, 0));
    vecs.push_back(mk(0, 0, 4'd0,  0, 0, 16'h2345, 4, 0, 23, 45, 0));
    // commit in HOLD is ignored
    vecs.push_back(mk(0, 0, 4'd0,  1, 0, 16'h2345, 4, 0, 23, 45, 0));
    vecs.push_back(mk(0, 0, 4'd0,  0, 0, 16'h2345, 4, 0, 23, 45, 0));
    vecs.push_back(mk(0, 0, 4'd0,  0, 0, 16'h2345, 4, 0, 23, 45, 0));
    // clear beats commit in ENTRY
    vecs.push_back(mk(0, 1, 4'd7,  0, 0, 16'h0007, 1, 0, 23, 45, 0));
    vecs.push_back(mk(0, 1, 4'd8,  0, 0, 16'h0078, 2, 0, 23, 45, 0));
    vecs.push_back(mk(0, 0, 4'd0,  1, 1, 16'h0000, 0, 0, 23, 45, 0));
    vecs.push_back(mk(0, 0, 4'd0,  0, 0, 16'h0000, 0, 0, 23, 45, 0));
    vecs.push_back(mk(0, 0, 4'd0,  0, 0, 16'h0000, 0, 0, 23, 45, 0));
    // reset during CONV aborts with no pulse
    vecs.push_back(mk(0, 1, 4'd4,  0, 0, 16'h0004, 1, 0, 23, 45, 0));
    vecs.push_back(mk(0, 0, 4'd0,  1, 0, 16'h0004, 1, 0, 23, 45, 0));
    vecs.push_back(mk(1, 0, 4'd0,  0, 0, 16'h0000, 0, 0, 0,  0,  0));
    vecs.push_back(mk(0, 0, 4'd0,  0, 0, 16'h0000, 0, 0, 0,  0,  0));
    vecs.push_back(mk(0, 0, 4'd0,  0, 0, 16'h0000, 0, 0, 0,  0,  0));
    // invalid key in ENTRY, key during CONV ignored
    vecs.push_back(mk(0, 1, 4'd2,  0, 0, 16'h0002, 1, 0, 0,  0,  0));
    vecs.push_back(mk(0, 1, 4'd15, 0, 0, 16'h0002, 1, 0, 0,  0,  0));
    vecs.push_back(mk(0, 0, 4'd0,  1, 0, 16'h0002, 1, 0, 0,  0,  0));
    vecs.push_back(mk(0, 1, 4'd6,  0, 0, 16'h0002, 1, 0, 0,  0,  0));
    vecs.push_back(mk(0, 0, 4'd0,  0, 0, 16'h0002, 1, 1, 0,  2,  0));
    // 59:60 carries to 60:00 and saturates
    vecs.push_back(mk(0, 1, 4'd5,  0, 0, 16'h0005, 1, 0, 0,  2,  0));
    vecs.push_back(mk(0, 1, 4'd9,  0, 0, 16'h0059, 2, 0, 0,  2,  0));
    vecs.push_back(mk(0, 1, 4'd6,  0, 0, 16'h0596, 3, 0, 0,  2,  0));
    vecs.push_back(mk(0, 1, 4'd0,  0, 0, 16'h5960, 4, 0, 0,  2,  0));
    vecs.push_back(mk(0, 0, 4'd0,  1, 0, 16'h5960, 4, 0, 0,  2,  0));
    vecs.push_back(mk(0, 0, 4'd0,  0, 0, 16'h5960, 4, 0, 0,  2,  0));
    vecs.push_back(mk(0, 0, 4'd0,  0, 0, 16'h5960, 4, 1, 59, 59, 1));
    // clear in HOLD keeps time, drops range_err
    vecs.push_back(mk(0, 0, 4'd0,  0, 1, 16'h0000, 0, 0, 59, 59, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      reset     = vecs[i].rst;
      key_valid = vecs[i].kv;
      key_digit = vecs[i].kd;
      commit    = vecs[i].cm;
      clear     = vecs[i].cl;
      step();
      chk("digits",      i, {ent_D3, ent_D2, ent_D1, ent_D0}, vecs[i].dig);
      chk("digit_count", i, 16'(digit_count), 16'(vecs[i].cnt));
      chk("time_valid",  i, 16'(time_valid),  16'(vecs[i].tv));
      chk("minutes",     i, 16'(minutes),     16'(vecs[i].mn));
      chk("seconds",     i, 16'(seconds),     16'(vecs[i].sc));
      chk("range_err",   i, 16'(range_err),   16'(vecs[i].re));
    end
    reset = 1'b0; key_valid = 1'b0; key_digit = 4'd0; commit = 1'b0; clear = 1'b0;

    // Bounded latency measurement: 1,3,0 then commit
    press(4'd1);
    press(4'd3);
    press(4'd0);
    commit = 1'b1;
    step();
    commit = 1'b0;
    lat = 0;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (time_valid) begin
        lat = c;
        break;
      end
    end
    chk("latency_edges", 100, 16'(lat), 16'd2);
    chk("lat_minutes",   100, 16'(minutes), 16'd1);
    chk("lat_seconds",   100, 16'(seconds), 16'd30);
    chk("lat_count",     100, 16'(digit_count), 16'd3);
    step();
    chk("pulse_width",   101, 16'(time_valid), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
